// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store controller bridging the pipeline to a valid/ready data bus.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_rs2_rdata,
    output logic        o_stall,
    output logic        o_load_valid,
    output logic [31:0] o_load_data,
    output logic        o_misalign,
    output logic        o_dmem_valid,
    input  logic        i_dmem_ready,
    output logic [31:0] o_dmem_addr,
    output logic        o_dmem_wen,
    output logic [3:0]  o_dmem_mask,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] load_data_q, load_data_d;
    logic [3:0]  mask_q, mask_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lane_q, lane_d;
    logic        wen_q, wen_d;
    logic        mis_q, mis_d;

    logic        req_byte, req_half, req_mis;
    logic [3:0]  req_mask;
    logic [31:0] req_wdata;
    logic [1:0]  req_lane;
    logic [31:0] rd_shift, rd_ext;

    always_comb begin : req_decode
        req_byte = (i_funct3 == 3'd0) || (i_funct3 == 3'd4);
        req_half = (i_funct3 == 3'd1) || (i_funct3 == 3'd5);
        if (req_byte) begin
            req_mask  = 4'b0001 << i_alu_result[1:0];
            req_wdata = {4{i_rs2_rdata[7:0]}};
            req_lane  = i_alu_result[1:0];
        end else if (req_half) begin
            req_mask  = i_alu_result[1] ? 4'b1100 : 4'b0011;
            req_wdata = {2{i_rs2_rdata[15:0]}};
            req_lane  = {i_alu_result[1], 1'b0};
        end else begin
            req_mask  = 4'b1111;
            req_wdata = i_rs2_rdata;
            req_lane  = 2'b00;
        end
`ifdef MEM_MISALIGN_TRAP_EN
        req_mis = (req_half && i_alu_result[0]) ||
                  (!req_byte && !req_half && (i_alu_result[1:0] != 2'b00));
`else
        req_mis = 1'b0;
`endif
    end

    // The lane is stored pre-aligned to the access size, so one shift serves byte, half and word.
    always_comb begin : load_extend
        rd_shift = i_dmem_rdata >> {lane_q, 3'b000};
        case (f3_q)
            3'd0:    rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'd4:    rd_ext = {24'b0, rd_shift[7:0]};
            3'd1:    rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'd5:    rd_ext = {16'b0, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    always_comb begin : fsm_next
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        load_data_d  = load_data_q;
        mask_d       = mask_q;
        f3_d         = f3_q;
        lane_d       = lane_q;
        wen_d        = wen_q;
        mis_d        = mis_q;
        o_stall      = 1'b0;
        o_dmem_valid = 1'b0;
        o_load_valid = 1'b0;
        o_misalign   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid && (i_mem_read || i_mem_write)) begin
                    o_stall = 1'b1;
                    addr_d  = {i_alu_result[31:2], 2'b00};
                    wdata_d = req_wdata;
                    mask_d  = req_mask;
                    f3_d    = i_funct3;
                    lane_d  = req_lane;
                    wen_d   = i_mem_write;
                    mis_d   = req_mis;
                    state_d = req_mis ? DONE : REQ;
                end
            end
            REQ: begin
                o_stall      = 1'b1;
                o_dmem_valid = 1'b1;
                if (i_dmem_ready) begin
                    state_d = wen_q ? DONE : WAIT;
                end
            end
            WAIT: begin
                o_stall = 1'b1;
                if (i_dmem_rvalid) begin
                    load_data_d = rd_ext;
                    state_d     = DONE;
                end
            end
            DONE: begin
                o_load_valid = !wen_q && !mis_q;
`ifdef MEM_MISALIGN_TRAP_EN
                o_misalign   = mis_q;
`endif
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            load_data_q <= '0;
            mask_q      <= '0;
            f3_q        <= '0;
            lane_q      <= '0;
            wen_q       <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            load_data_q <= load_data_d;
            mask_q      <= mask_d;
            f3_q        <= f3_d;
            lane_q      <= lane_d;
            wen_q       <= wen_d;
            mis_q       <= mis_d;
        end
    end

    assign o_dmem_addr  = addr_q;
    assign o_dmem_wen   = wen_q;
    assign o_dmem_mask  = mask_q;
    assign o_dmem_wdata = wdata_q;
    assign o_load_data  = load_data_q;

endmodule
